// File: rtl/pipelined_adder_if.sv
// Valid/ready streaming bundle for pipelined_adder: operand beat in, result beat out.
// master drives operands and out_ready; slave is the adder.
interface pipelined_adder_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] val1;
    logic [WIDTH-1:0] val2;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] valOut;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, val1, val2, cin, sub, out_ready,
        input  in_ready, out_valid, valOut, cout, ovf, zero
    );

    modport slave (
        input  in_valid, val1, val2, cin, sub, out_ready,
        output in_ready, out_valid, valOut, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES registered ripple-carry slices.
// Stage k adds slice k; operands and partial results travel with the beat.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    pipelined_adder_if.slave   io
);
    localparam int unsigned CW = WIDTH / STAGES;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    logic adv;

    logic [STAGES-1:0]            v_q, v_d;
    logic [STAGES-1:0]            c_q, c_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic [STAGES-1:0][WIDTH-1:0] r_q, r_d;

    // Element k of each chain is the input to stage k; element STAGES is the final register.
    logic [STAGES:0]              v_chain, c_chain;
    logic [STAGES:0][WIDTH-1:0]   a_chain, b_chain, r_chain;
    logic [CW:0]                  sum;
    logic                         unused_chain;

    assign adv = ~v_q[STAGES-1] | io.out_ready;

    assign v_chain = {v_q, io.in_valid};
    assign c_chain = {c_q, io.sub | io.cin};
    assign a_chain = {a_q, io.val1};
    assign b_chain = {b_q, io.sub ? ~io.val2 : io.val2};
    assign r_chain = {r_q, {WIDTH{1'b0}}};

    assign unused_chain = ^{a_chain[STAGES], b_chain[STAGES], r_chain[STAGES],
                            c_chain[STAGES], v_chain[STAGES]};

    always_comb begin
        v_d = '0;
        c_d = '0;
        a_d = '0;
        b_d = '0;
        r_d = '0;
        sum = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            sum = {1'b0, a_chain[k][k*CW +: CW]} + {1'b0, b_chain[k][k*CW +: CW]}
                + {{CW{1'b0}}, c_chain[k]};
            v_d[k] = v_chain[k];
            a_d[k] = a_chain[k];
            b_d[k] = b_chain[k];
            r_d[k] = r_chain[k];
            r_d[k][k*CW +: CW] = sum[CW-1:0];
            c_d[k] = sum[CW];
        end
    end

    // Bubbles shift like beats; a stall freezes every stage including the outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q <= '0;
            c_q <= '0;
            a_q <= '0;
            b_q <= '0;
            r_q <= '0;
        end else if (adv) begin
            v_q <= v_d;
            c_q <= c_d;
            a_q <= a_d;
            b_q <= b_d;
            r_q <= r_d;
        end
    end

    assign io.in_ready  = adv;
    assign io.out_valid = v_q[STAGES-1];
    assign io.valOut    = r_q[STAGES-1];
    assign io.cout      = c_q[STAGES-1];
    assign io.ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
                        & (r_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
    assign io.zero      = (r_q[STAGES-1] == '0);
endmodule
